mem_initiator: RTL

- Command-side master for the valid/ready single-port memory responder.
- Accepts a job: fill an address range with a deterministic pattern (WRITE), or read the range back and check it (CHECK).
- Drives the responder's command channel, consumes its read-response channel, and reports completion and mismatch counts.
- Used as a built-in memory self-test engine and as the traffic source in responder block tests.

---
 rtl/mem_init_pkg.sv | 14 +
 rtl/mem_rsp_check.sv | 52 +++++
 rtl/mem_initiator.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mem_init_pkg.sv
// Shared encodings for the memory self-test initiator and its response checker.
package mem_init_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic OP_WR  = 1'b1;
  localparam logic OP_CHK = 1'b0;

endpackage

// File: rtl/mem_rsp_check.sv
// In-order read-response checker: counts responses and records mismatches
// against the job pattern (address base+i, data seed+i).
module mem_rsp_check
  import mem_init_pkg::*;
#(
  parameter int DATA_WD = 4,
  parameter int ADDR_WD = 4,
  parameter int LEN_WD  = ADDR_WD + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic [ADDR_WD-1:0] base_addr,
  input  logic [DATA_WD-1:0] seed,
  input  logic               rsp_fire,
  input  logic [DATA_WD-1:0] rsp_data,
  output logic [LEN_WD-1:0]  rcv,
  output logic [LEN_WD-1:0]  err_cnt,
  output logic [ADDR_WD-1:0] first_err_addr
);

  logic [DATA_WD-1:0] exp_data_s;
  logic [ADDR_WD-1:0] exp_addr_s;
  logic               mismatch_s;

  // Expected word for the response index currently awaited.
  always_comb begin
    exp_data_s = seed + DATA_WD'(rcv);
    exp_addr_s = base_addr + ADDR_WD'(rcv);
    mismatch_s = rsp_fire && (rsp_data != exp_data_s);
  end

  // Response counter and first-mismatch capture; cleared when a job starts.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rcv            <= '0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else begin
      if (rsp_fire) begin
        rcv <= rcv + LEN_WD'(1);
      end
      if (mismatch_s) begin
        err_cnt <= err_cnt + LEN_WD'(1);
        if (err_cnt == '0) begin
          first_err_addr <= exp_addr_s;
        end
      end
    end
  end

endmodule

// File: rtl/mem_initiator.sv
// Memory self-test initiator: fills an address range with a seed pattern
// (WRITE) or reads it back and counts mismatches (CHECK).
module mem_initiator
  import mem_init_pkg::*;
#(
  parameter int DATA_WD = 4,
  parameter int ADDR_WD = 4,
  parameter int LEN_WD  = ADDR_WD + 1,
  parameter int MAX_OUT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               op_wr,
  input  logic [ADDR_WD-1:0] base_addr,
  input  logic [LEN_WD-1:0]  len,
  input  logic [DATA_WD-1:0] seed,
  output logic               busy,
  output logic               done,
  output logic [LEN_WD-1:0]  err_cnt,
  output logic [ADDR_WD-1:0] first_err_addr,
  output logic               cmd_valid,
  output logic               cmd_wr,
  output logic [ADDR_WD-1:0] cmd_addr,
  output logic [DATA_WD-1:0] cmd_data,
  input  logic               cmd_ready,
  input  logic               rsp_valid,
  input  logic [DATA_WD-1:0] rsp_data,
  output logic               rsp_ready
);

  state_t             state_r, state_s;
  logic               op_wr_r, op_s;
  logic [ADDR_WD-1:0] base_r;
  logic [LEN_WD-1:0]  len_r, iss_r, iss_s, rcv_r, rcv_s;
  logic [DATA_WD-1:0] seed_r;
  logic               start_s, cmd_fire_s, rsp_fire_s, credit_s;
  logic               cmd_valid_s, cmd_wr_s;
  logic [ADDR_WD-1:0] cmd_addr_s;
  logic [DATA_WD-1:0] cmd_data_s;

  // Next-state decode plus this cycle's transfer bookkeeping.
  always_comb begin
    cmd_fire_s = cmd_valid && cmd_ready;
    rsp_fire_s = rsp_valid && rsp_ready;
    iss_s      = iss_r + LEN_WD'(cmd_fire_s);
    rcv_s      = rcv_r + LEN_WD'(rsp_fire_s);
    start_s    = 1'b0;
    state_s    = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          start_s = 1'b1;
          state_s = (len == '0) ? DONE : ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (cmd_fire_s && (iss_r == len_r - LEN_WD'(1))) begin
          state_s = (op_wr_r == OP_WR) ? DONE : DRAIN;
        end else begin
          state_s = ISSUE;
        end
      end
      DRAIN: begin
        if (rcv_r == len_r) begin
          state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next command: hold a stalled one, otherwise offer the next word when
  // words remain and (for reads) a response credit is free.
  always_comb begin
    op_s        = start_s ? op_wr : op_wr_r;
    credit_s    = (op_wr_r == OP_WR) || ((iss_s - rcv_s) < LEN_WD'(MAX_OUT));
    cmd_valid_s = 1'b0;
    cmd_wr_s    = cmd_wr;
    cmd_addr_s  = cmd_addr;
    cmd_data_s  = cmd_data;
    if (start_s) begin
      cmd_valid_s = (len != '0);
      cmd_wr_s    = op_wr;
      cmd_addr_s  = base_addr;
      cmd_data_s  = seed;
    end else if ((state_r == ISSUE) && (state_s == ISSUE)) begin
      if (cmd_valid && !cmd_ready) begin
        cmd_valid_s = 1'b1;
      end else begin
        cmd_valid_s = (iss_s < len_r) && credit_s;
        cmd_addr_s  = base_r + ADDR_WD'(iss_s);
        cmd_data_s  = seed_r + DATA_WD'(iss_s);
      end
    end else begin
      cmd_valid_s = 1'b0;
    end
  end

  // State, job latches, issue counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      op_wr_r   <= OP_CHK;
      base_r    <= '0;
      len_r     <= '0;
      seed_r    <= '0;
      iss_r     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_wr    <= 1'b0;
      cmd_addr  <= '0;
      cmd_data  <= '0;
      rsp_ready <= 1'b0;
    end else begin
      state_r   <= state_s;
      busy      <= (state_s != IDLE);
      done      <= (state_s == DONE);
      rsp_ready <= ((state_s == ISSUE) || (state_s == DRAIN)) && (op_s == OP_CHK);
      cmd_valid <= cmd_valid_s;
      cmd_wr    <= cmd_wr_s;
      cmd_addr  <= cmd_addr_s;
      cmd_data  <= cmd_data_s;
      if (start_s) begin
        op_wr_r <= op_wr;
        base_r  <= base_addr;
        len_r   <= len;
        seed_r  <= seed;
        iss_r   <= '0;
      end else begin
        iss_r   <= iss_s;
      end
    end
  end

  mem_rsp_check #(
    .DATA_WD (DATA_WD),
    .ADDR_WD (ADDR_WD),
    .LEN_WD  (LEN_WD)
  ) u_rsp_check (
    .clk            (clk),
    .rst            (rst),
    .clear          (start_s),
    .base_addr      (base_r),
    .seed           (seed_r),
    .rsp_fire       (rsp_fire_s),
    .rsp_data       (rsp_data),
    .rcv            (rcv_r),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr)
  );

endmodule
